// File: rtl/move_bit_serializer.sv
// move_bit_serializer
//   Buffers whole move words in a small FIFO and shifts each one out MSB-first
//   on x, one bit per bit_en cycle, to drive the move-recognition FSM.
//
// Ports
//   CLK         rising-edge clock
//   RESET       synchronous, active-high reset
//   in_valid    producer presents a word on in_data
//   in_data     move word, MSB transmitted first
//   in_ready    FIFO can accept a word this cycle (registered state only)
//   bit_en      advance the serial stream by one bit
//   x           registered serial bit (IDLE_BIT when no word is shifting)
//   x_valid     registered, x carries a word bit
//   word_done   last bit of the current word is consumed this cycle
//   fifo_count  words held in the FIFO, excluding the shifter
//   busy        FIFO non-empty or shifter active
module move_bit_serializer #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 4,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   input  logic                       bit_en,
   output logic                       x,
   output logic                       x_valid,
   output logic                       word_done,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BIT_W-1:0] bitcnt, bitcnt_n;
   logic             push, pop;
   logic             fifo_empty, fifo_full;
   logic             x_n;

   assign fifo_full  = (count == CNT_W'(DEPTH));
   assign fifo_empty = (count == '0);

   // Ready depends only on the stored count, so a same-edge pop never
   // opens a slot combinationally.
   assign in_ready   = !RESET && !fifo_full;
   assign push       = in_valid && in_ready;

   assign word_done  = (state == SHIFT) && (bitcnt == '0) && bit_en;
   assign busy       = !fifo_empty || (state == SHIFT);
   assign fifo_count = count;

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               shreg_n  = mem[rd_ptr];
               bitcnt_n = BIT_W'(WIDTH - 1);
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_en) begin
               if (bitcnt != '0) begin
                  shreg_n  = {shreg[WIDTH-2:0], 1'b0};
                  bitcnt_n = bitcnt - BIT_W'(1);
               end else if (!fifo_empty) begin
                  // back-to-back reload keeps the stream gap-free
                  pop      = 1'b1;
                  shreg_n  = mem[rd_ptr];
                  bitcnt_n = BIT_W'(WIDTH - 1);
               end else begin
                  state_n  = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // x/x_valid are registered from the next-state view so they line up
   // with the shifter contents after each edge.
   assign x_n = (state_n == SHIFT) ? shreg_n[WIDTH-1] : IDLE_BIT;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         shreg   <= '0;
         bitcnt  <= '0;
         x       <= IDLE_BIT;
         x_valid <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bitcnt  <= bitcnt_n;
         x       <= x_n;
         x_valid <= (state_n == SHIFT);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_move_bit_serializer.sv
// tb_move_bit_serializer
//   Drives move_bit_serializer with directed and random traffic and compares
//   every output each cycle against a queue-based reference model; a separate
//   deserializer rebuilds words from x and matches them to accepted words.
module tb_move_bit_serializer;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned DEPTH    = 4;
   localparam logic        IDLE_BIT = 1'b1;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

   logic             CLK = 1'b0;
   logic             RESET;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             bit_en;
   logic             x;
   logic             x_valid;
   logic             word_done;
   logic [CNT_W-1:0] fifo_count;
   logic             busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 CLK = ~CLK;

   move_bit_serializer #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .IDLE_BIT (IDLE_BIT)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .bit_en     (bit_en),
      .x          (x),
      .x_valid    (x_valid),
      .word_done  (word_done),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   // reference model: queued words, current word and index of the bit on x
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] cur;
   int               pos;
   bit               active;

   logic [WIDTH-1:0] src[$];   // words waiting to be offered
   logic [WIDTH-1:0] sent[$];  // words accepted, in order
   logic [WIDTH-1:0] acc;
   int unsigned      acc_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: apply inputs after negedge, check, update model, advance
   task automatic step(input bit r, input bit en, input bit want_v);
      logic exp_ready, exp_done, exp_x, accept;
      RESET    = r;
      bit_en   = en;
      in_valid = want_v && (src.size() > 0);
      in_data  = in_valid ? src[0] : WIDTH'($urandom);
      #2;
      exp_ready = !r && (mq.size() < DEPTH);
      exp_done  = active && (pos == WIDTH - 1) && en;
      exp_x     = active ? cur[WIDTH-1-pos] : IDLE_BIT;
      check("in_ready",   32'(in_ready),   32'(exp_ready));
      check("x",          32'(x),          32'(exp_x));
      check("x_valid",    32'(x_valid),    32'(active));
      check("word_done",  32'(word_done),  32'(exp_done));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("busy",       32'(busy),       32'((mq.size() != 0) || active));

      // deserializer built purely from DUT outputs
      if (x_valid && en) begin
         acc   = {acc[WIDTH-2:0], x};
         acc_n = acc_n + 1;
      end
      if (word_done) begin
         check("sb_bits", 32'(acc_n), 32'(WIDTH));
         if (sent.size() == 0) check("sb_underflow", 32'(sent.size()), 32'd1);
         else                  check("sb_word", 32'(acc), 32'(sent.pop_front()));
         acc_n = 0;
      end

      accept = in_valid && exp_ready;
      if (r) begin
         mq.delete();
         sent.delete();
         active = 1'b0;
         pos    = 0;
         acc_n  = 0;
      end else begin
         if ((!active || exp_done) && (mq.size() > 0)) begin
            cur    = mq.pop_front();
            pos    = 0;
            active = 1'b1;
         end else if (exp_done) begin
            active = 1'b0;
         end else if (active && en) begin
            pos++;
         end
         if (accept) begin
            mq.push_back(in_data);
            sent.push_back(in_data);
            void'(src.pop_front());
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      active   = 1'b0;
      pos      = 0;
      acc      = '0;
      acc_n    = 0;
      RESET    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      bit_en   = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);

      // reset held: in_ready low, outputs idle
      step(1, 1, 0);
      step(1, 1, 0);

      // single word 0xA5
      src.push_back(8'hA5);
      repeat (14) step(0, 1, 1);

      // 0xFF then 0x00 back-to-back
      src.push_back(8'hFF);
      src.push_back(8'h00);
      repeat (22) step(0, 1, 1);

      // fill with bit_en low, then release
      for (int i = 1; i <= 6; i++) src.push_back(WIDTH'(i));
      repeat (10) step(0, 0, 1);
      repeat (60) step(0, 1, 1);

      // 0xC3 with sparse enable
      src.push_back(8'hC3);
      for (int i = 0; i < 40; i++) step(0, (i % 3) == 0, 1);

      // reset mid-word, then clean word 0x81
      src.push_back(8'hF0);
      repeat (5) step(0, 1, 1);
      step(1, 1, 0);
      src.push_back(8'h81);
      repeat (14) step(0, 1, 1);

      // continuous stream with incrementing data
      for (int i = 0; i < 220; i++) src.push_back(WIDTH'(i + 16));
      repeat (200) step(0, 1, 1);
      src.delete();
      repeat (60) step(0, 1, 0);

      // random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         if (src.size() < 2) src.push_back(WIDTH'($urandom));
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      src.delete();
      repeat (80) step(0, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
